mem_sram_ctrl: RTL and testbench
================================

// Module: mem_sram_ctrl
// PURPOSE
// - MEM-stage consumer of the EXE->MEM pipeline register. Performs the 32-bit data access via an
//   external 16-bit asynchronous SRAM as two half-word accesses (low, then high).
// - Drives ready=0 to stall the pipeline while an access is in flight.
// - Read data goes to the MEM->WB register.
// PARAMETERS
// - WAIT_CYCLES  3        clock cycles per half-word phase; legal range >=1
// - BASE_ADDR    1024     byte address mapped to SRAM half-word 0
// - SRAM_AW      18       SRAM half-word address width
// PORTS
// Reset: one clock; reset is synchronous and active-low.
// - clk         in   1        rising-edge clock
// - rst         in   1        synchronous, active-low reset (0 = reset)
// - MEM_R_EN    in   1        load request from EXE->MEM register
// - MEM_W_EN    in   1        store request from EXE->MEM register
// - ALU_result  in   32       byte address; word-aligned
// - ST_val      in   32       store data
// - ready       out  1        0 = stall pipeline; 1 = access complete, or no access requested
// - rdata       out  32       load result; held until the next load completes
// - SRAM_ADDR   out  SRAM_AW  SRAM half-word address
// - SRAM_WE_N   out  1        SRAM write enable, active-low
// - dq_out      out  16       data driven to SRAM
// - dq_oe       out  1        1 = drive dq_out onto the bus
// - dq_in       in   16       data read from SRAM
// BEHAVIOUR
// - Reset (rst=0 at a clk edge):
//   - Next state: state=IDLE, counter=0.
//   - Outputs: rdata=0, SRAM_ADDR=0, SRAM_WE_N=1, dq_out=0, dq_oe=0.
//   - Internal regs: addr_q=0, wdata_q=0.
//   - Mid-access reset aborts at once. A partially written word is left as-is; no completion.
// - State machine: IDLE -> LO -> HI -> DONE -> IDLE.
//   - IDLE:
//     - MEM_R_EN or MEM_W_EN seen -> latch addr_q=(ALU_result-BASE_ADDR)>>2, wdata_q=ST_val,
//       is_wr=MEM_W_EN; go to LO.
//     - If both enables are high, the write wins.
//   - LO:
//     - SRAM_ADDR={addr_q,1'b0}; stay WAIT_CYCLES cycles.
//     - Write: SRAM_WE_N=0, dq_oe=1, dq_out=wdata_q[15:0].
//     - Read: SRAM_WE_N=1, dq_oe=0; rdata[15:0]<=dq_in on the last LO cycle.
//   - HI:
//     - Same as LO with SRAM_ADDR={addr_q,1'b1}, wdata_q[31:16], rdata[31:16].
//   - DONE: one cycle. SRAM_WE_N=1, dq_oe=0; next state IDLE.
// - ready: combinational; ready = ~(MEM_R_EN|MEM_W_EN) | (state==DONE).
// - Latency: request first seen in IDLE at cycle t.
//   - LO spans t+1..t+W, HI spans t+W+1..t+2W, ready=1 in DONE at cycle t+2W+1.
//   - The pipeline advances at the end of that cycle.
// - Upstream holds MEM_R_EN/MEM_W_EN/ALU_result/ST_val stable while ready=0. Block uses latched copies.
// - Back-to-back accesses: DONE->IDLE, the next request is sampled in IDLE. One idle cycle between accesses.
// - Wait counter:
//   - Counts 0..WAIT_CYCLES-1 and resets to 0 on each phase change.
//   - Width $clog2(WAIT_CYCLES+1).
// - Address arithmetic: 32-bit modulo subtract. Result truncated to SRAM_AW-1 bits before the half select.
// - SRAM_WE_N, SRAM_ADDR, dq_out and dq_oe decode from state/addr_q/wdata_q only. No combinational
//   path from request inputs.
// - rdata is not modified by writes or by aborted reads, except by reset.
// STRUCTURE
// - Package mem_pkg holds:
//   - state enum {IDLE,LO,HI,DONE}
//   - default BASE_ADDR
//   - SRAM data width (16)
//   - SRAM_AW
// - One sub-module: sram_wait_counter. Load/clear on phase entry; outputs last_cycle.
// - FSM, address/data latches and rdata halves live in this module.
// TESTING
// - Reset:
//   - Drive rst=0 for 2 cycles with MEM_R_EN=1.
//   - Expect: state IDLE, SRAM_WE_N=1, dq_oe=0, rdata=0.
//   - Expect: ready=0 once rst=1, because a request is pending.
// - Store:
//   - Stimulus: W=3, MEM_W_EN=1, ALU_result=1028, ST_val=0xDEADBEEF.
//   - Expect LO: SRAM_ADDR=2, dq_out=0xBEEF, WE_N=0 for 3 cycles.
//   - Expect HI: SRAM_ADDR=3, dq_out=0xDEAD.
//   - Expect ready=1 exactly 7 cycles after the request.
// - Load:
//   - Stimulus: MEM_R_EN=1, ALU_result=1028, SRAM model returns 0xBEEF@2 and 0xDEAD@3.
//   - Expect: rdata=0xDEADBEEF in the DONE cycle, dq_oe=0 throughout.
// - No request:
//   - Stimulus: both enables low for 10 cycles.
//   - Expect: ready=1 every cycle, state stays IDLE, WE_N=1.
// - Simultaneous enables and back-to-back:
//   - Stimulus: MEM_R_EN=MEM_W_EN=1, then an immediate load.
//   - Expect: a write is performed; one IDLE cycle after DONE; the load completes 8 cycles after the first DONE.
// - Mid-access reset:
//   - Stimulus: rst=0 during HI of a write.
//   - Expect: WE_N=1 and dq_oe=0 the next cycle; state IDLE; the LO half stays written.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage SRAM controller.
// Holds the controller state type, the SRAM data width and default address parameters.
package mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi,
    StDone
  } state_e;

  localparam int unsigned SRAM_DW           = 16;
  localparam int unsigned SRAM_AW_DEFAULT   = 18;
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

endpackage

// File: rtl/mem_sram_ctrl_if.sv
// Bundle of the pipeline request/response signals and the SRAM bus signals.
// Ports (signals):
//   MEM_R_EN, MEM_W_EN, ALU_result, ST_val : pipeline request (master -> slave)
//   ready, rdata                           : pipeline response (slave -> master)
//   SRAM_ADDR, SRAM_WE_N, dq_out, dq_oe    : SRAM control/data out (slave -> master)
//   dq_in                                  : SRAM read data (master -> slave)
interface mem_sram_ctrl_if #(
  parameter int unsigned SRAM_AW = mem_pkg::SRAM_AW_DEFAULT
);
  import mem_pkg::*;

  logic                 MEM_R_EN;
  logic                 MEM_W_EN;
  logic [31:0]          ALU_result;
  logic [31:0]          ST_val;
  logic                 ready;
  logic [31:0]          rdata;
  logic [SRAM_AW-1:0]   SRAM_ADDR;
  logic                 SRAM_WE_N;
  logic [SRAM_DW-1:0]   dq_out;
  logic                 dq_oe;
  logic [SRAM_DW-1:0]   dq_in;

  modport master (
    output MEM_R_EN, MEM_W_EN, ALU_result, ST_val, dq_in,
    input  ready, rdata, SRAM_ADDR, SRAM_WE_N, dq_out, dq_oe
  );

  modport slave (
    input  MEM_R_EN, MEM_W_EN, ALU_result, ST_val, dq_in,
    output ready, rdata, SRAM_ADDR, SRAM_WE_N, dq_out, dq_oe
  );

endinterface

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter for the SRAM controller.
// Counts 0..WAIT_CYCLES-1 while en is high and wraps to 0 on the last cycle, so each new
// phase starts from 0.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-low reset
//   en         : high while a half-word phase is active
//   last_cycle : high on the final cycle of the current phase
module sram_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic last_cycle
);

  localparam int unsigned CntW = $clog2(WAIT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign last_cycle = en && (cnt_q == CntW'(WAIT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (!en || last_cycle) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM-stage controller performing 32-bit loads/stores through a 16-bit async SRAM as two
// half-word phases (low, then high). Stalls the pipeline with ready=0 while busy.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : mem_sram_ctrl_if.slave (pipeline request/response and SRAM bus)
module mem_sram_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int unsigned SRAM_AW     = SRAM_AW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  mem_sram_ctrl_if.slave  bus
);

  localparam int unsigned AddrW = SRAM_AW - 1;

  state_e            state_q, state_d;
  logic [AddrW-1:0]  addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              is_wr_q;
  logic              req;
  logic              phase_en;
  logic              last_cycle;
  logic [31:0]       offset;
  logic              unused_offset;

  assign req      = bus.MEM_R_EN | bus.MEM_W_EN;
  assign phase_en = (state_q == StLo) || (state_q == StHi);

  // Modulo-2^32 subtract; word index truncated to leave room for the half select bit.
  assign offset        = bus.ALU_result - BASE_ADDR;
  assign unused_offset = ^{offset[1:0], offset[31:AddrW+2]};

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .en         (phase_en),
    .last_cycle (last_cycle)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req) state_d = StLo;
      StLo:    if (last_cycle) state_d = StHi;
      StHi:    if (last_cycle) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request is latched once in IDLE; write wins when both enables are set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (state_q == StIdle && req) begin
        addr_q  <= offset[AddrW+1:2];
        wdata_q <= bus.ST_val;
        is_wr_q <= bus.MEM_W_EN;
      end
      if (!is_wr_q && last_cycle) begin
        if (state_q == StLo) rdata_q[15:0]  <= bus.dq_in;
        if (state_q == StHi) rdata_q[31:16] <= bus.dq_in;
      end
    end
  end

  // SRAM outputs depend only on registered state, never on the request inputs.
  always_comb begin
    bus.SRAM_ADDR = '0;
    bus.SRAM_WE_N = 1'b1;
    bus.dq_out    = '0;
    bus.dq_oe     = 1'b0;
    unique case (state_q)
      StLo: begin
        bus.SRAM_ADDR = {addr_q, 1'b0};
        if (is_wr_q) begin
          bus.SRAM_WE_N = 1'b0;
          bus.dq_oe     = 1'b1;
          bus.dq_out    = wdata_q[15:0];
        end
      end
      StHi: begin
        bus.SRAM_ADDR = {addr_q, 1'b1};
        if (is_wr_q) begin
          bus.SRAM_WE_N = 1'b0;
          bus.dq_oe     = 1'b1;
          bus.dq_out    = wdata_q[31:16];
        end
      end
      default: ;
    endcase
  end

  assign bus.ready = ~req | (state_q == StDone);
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed self-checking bench for mem_sram_ctrl with a behavioural 16-bit async SRAM.
module tb_mem_sram_ctrl;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_sram_ctrl_if bus ();

  mem_sram_ctrl #(
    .WAIT_CYCLES (3),
    .BASE_ADDR   (32'd1024),
    .SRAM_AW     (18)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] sram_mem [0:255] = '{default: 16'h0000};

  always @(posedge clk) begin
    if (bus.SRAM_WE_N === 1'b0) sram_mem[bus.SRAM_ADDR[7:0]] <= bus.dq_out;
  end

  assign bus.dq_in = sram_mem[bus.SRAM_ADDR[7:0]];

  // Drive and sample on the falling edge, away from the active edge.
  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    int n;
    bus.MEM_R_EN   = 1'b1;
    bus.ALU_result = 32'd1028;
    rst = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (dut.state_q !== StIdle) begin
      n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, StIdle);
    end
    n_checks++;
    if (bus.SRAM_WE_N !== 1'b1 || bus.dq_oe !== 1'b0) begin
      n_fail++; $display("FAIL reset_sram: we_n=%b oe=%b want 1 0", bus.SRAM_WE_N, bus.dq_oe);
    end
    n_checks++;
    if (bus.rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.rdata);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_pending: got %b want 0", bus.ready);
    end
    // Pending load runs to completion against zeroed SRAM.
    n = 0;
    while (n < 40) begin
      tick(); n++;
      if (bus.ready === 1'b1) break;
    end
    n_checks++;
    if (n != 7 || bus.rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_first_load: cycles=%0d rdata=%h want 7 0", n, bus.rdata);
    end
    bus.MEM_R_EN = 1'b0;
    tick();
  endtask

  task automatic test_store;
    bus.MEM_W_EN   = 1'b1;
    bus.ALU_result = 32'd1028;
    bus.ST_val     = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (bus.ready !== 1'b0) begin
      n_fail++; $display("FAIL store_ready_idle: got %b want 0", bus.ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({bus.SRAM_ADDR, bus.dq_out, bus.SRAM_WE_N, bus.dq_oe, bus.ready}
          !== {18'd2, 16'hBEEF, 1'b0, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL store_lo[%0d]: addr=%0d dq=%h we_n=%b oe=%b rdy=%b want 2 beef 0 1 0",
                 i, bus.SRAM_ADDR, bus.dq_out, bus.SRAM_WE_N, bus.dq_oe, bus.ready);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({bus.SRAM_ADDR, bus.dq_out, bus.SRAM_WE_N, bus.dq_oe, bus.ready}
          !== {18'd3, 16'hDEAD, 1'b0, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL store_hi[%0d]: addr=%0d dq=%h we_n=%b oe=%b rdy=%b want 3 dead 0 1 0",
                 i, bus.SRAM_ADDR, bus.dq_out, bus.SRAM_WE_N, bus.dq_oe, bus.ready);
      end
    end
    tick();
    n_checks++;
    if (bus.ready !== 1'b1 || dut.state_q !== StDone || bus.SRAM_WE_N !== 1'b1) begin
      n_fail++;
      $display("FAIL store_done: rdy=%b state=%0d we_n=%b want 1 %0d 1",
               bus.ready, dut.state_q, bus.SRAM_WE_N, StDone);
    end
    bus.MEM_W_EN = 1'b0;
    tick();
    n_checks++;
    if (sram_mem[2] !== 16'hBEEF || sram_mem[3] !== 16'hDEAD) begin
      n_fail++; $display("FAIL store_mem: got %h %h want beef dead", sram_mem[2], sram_mem[3]);
    end
    n_checks++;
    if (bus.rdata !== 32'h0) begin
      n_fail++; $display("FAIL store_rdata_kept: got %h want 0", bus.rdata);
    end
  endtask

  task automatic test_load;
    int n;
    logic bad_oe;
    bus.MEM_R_EN   = 1'b1;
    bus.ALU_result = 32'd1028;
    bad_oe = 1'b0;
    n = 0;
    while (n < 40) begin
      tick(); n++;
      if (bus.dq_oe !== 1'b0 || bus.SRAM_WE_N !== 1'b1) bad_oe = 1'b1;
      if (bus.ready === 1'b1) break;
    end
    n_checks++;
    if (bad_oe) begin
      n_fail++; $display("FAIL load_oe: got driven bus during load want oe=0 we_n=1");
    end
    n_checks++;
    if (n != 7 || bus.rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL load_data: cycles=%0d rdata=%h want 7 deadbeef", n, bus.rdata);
    end
    bus.MEM_R_EN = 1'b0;
    tick();
  endtask

  task automatic test_no_request;
    int bad;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.ready !== 1'b1 || dut.state_q !== StIdle || bus.SRAM_WE_N !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL no_request: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    logic saw_we;
    bus.MEM_R_EN   = 1'b1;
    bus.MEM_W_EN   = 1'b1;
    bus.ALU_result = 32'd1036;
    bus.ST_val     = 32'h12345678;
    saw_we = 1'b0;
    n = 0;
    while (n < 40) begin
      tick(); n++;
      if (bus.SRAM_WE_N === 1'b0) saw_we = 1'b1;
      if (bus.ready === 1'b1) break;
    end
    n_checks++;
    if (!saw_we || n != 7 || dut.state_q !== StDone) begin
      n_fail++;
      $display("FAIL both_en_write: saw_we=%b cycles=%0d state=%0d want 1 7 %0d",
               saw_we, n, dut.state_q, StDone);
    end
    bus.MEM_W_EN = 1'b0;
    tick();
    n_checks++;
    if (dut.state_q !== StIdle || bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle_gap: state=%0d rdy=%b want %0d 0", dut.state_q, bus.ready, StIdle);
    end
    n = 1;
    while (n < 40) begin
      tick(); n++;
      if (bus.ready === 1'b1) break;
    end
    n_checks++;
    if (n != 8 || bus.rdata !== 32'h12345678) begin
      n_fail++; $display("FAIL b2b_load: cycles=%0d rdata=%h want 8 12345678", n, bus.rdata);
    end
    n_checks++;
    if (sram_mem[6] !== 16'h5678 || sram_mem[7] !== 16'h1234) begin
      n_fail++; $display("FAIL b2b_mem: got %h %h want 5678 1234", sram_mem[6], sram_mem[7]);
    end
    bus.MEM_R_EN = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset;
    bus.MEM_W_EN   = 1'b1;
    bus.ALU_result = 32'd1040;
    bus.ST_val     = 32'hAAAA5555;
    repeat (4) tick();
    n_checks++;
    if (dut.state_q !== StHi) begin
      n_fail++; $display("FAIL midrst_in_hi: state=%0d want %0d", dut.state_q, StHi);
    end
    rst = 1'b0;
    bus.MEM_W_EN = 1'b0;
    tick();
    n_checks++;
    if (bus.SRAM_WE_N !== 1'b1 || bus.dq_oe !== 1'b0 || dut.state_q !== StIdle) begin
      n_fail++;
      $display("FAIL midrst_abort: we_n=%b oe=%b state=%0d want 1 0 %0d",
               bus.SRAM_WE_N, bus.dq_oe, dut.state_q, StIdle);
    end
    n_checks++;
    if (bus.rdata !== 32'h0) begin
      n_fail++; $display("FAIL midrst_rdata: got %h want 0", bus.rdata);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (sram_mem[8] !== 16'h5555 || bus.ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_lo_kept: mem=%h rdy=%b want 5555 1", sram_mem[8], bus.ready);
    end
  endtask

  initial begin
    rst            = 1'b0;
    bus.MEM_R_EN   = 1'b0;
    bus.MEM_W_EN   = 1'b0;
    bus.ALU_result = 32'h0;
    bus.ST_val     = 32'h0;
    test_reset();
    test_store();
    test_load();
    test_no_request();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
